// File: rtl/trace_pkg.sv
// Shared types and constants for the trace line parser: op codes, parser
// states, ASCII constants and the decoded request record.
package trace_pkg;

    localparam int TRACE_TIME_W = 64;
    localparam int TRACE_CORE_W = 4;
    localparam int TRACE_ADDR_W = 34;

    typedef enum logic [1:0] {
        OP_READ   = 2'd0,
        OP_WRITE  = 2'd1,
        OP_IFETCH = 2'd2
    } op_e;

    typedef enum logic [2:0] {
        LINE_START = 3'd0,
        FIELD      = 3'd1,
        GAP        = 3'd2,
        EMIT       = 3'd3,
        DRAIN      = 3'd4
    } state_e;

    localparam logic [7:0] CH_NL  = 8'h0A;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_SP  = 8'h20;
    localparam logic [7:0] CH_TAB = 8'h09;

    typedef struct packed {
        logic [TRACE_TIME_W-1:0] tstamp;
        logic [TRACE_CORE_W-1:0] core;
        op_e                     op;
        logic [TRACE_ADDR_W-1:0] addr;
    } trace_req_t;

endpackage

// File: rtl/trace_line_parser_if.sv
// Character stream in, decoded request out. The byte source / request sink
// uses the master modport; the parser uses the slave modport.
interface trace_line_parser_if #(
    parameter int TIME_W = 64,
    parameter int CORE_W = 4,
    parameter int ADDR_W = 34
);
    logic              ch_valid;
    logic [7:0]        ch_data;
    logic              ch_ready;
    logic              req_valid;
    logic              req_ready;
    logic [TIME_W-1:0] req_time;
    logic [CORE_W-1:0] req_core;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;

    modport master (
        output ch_valid, ch_data, req_ready,
        input  ch_ready, req_valid, req_time, req_core, req_op, req_addr
    );

    modport slave (
        input  ch_valid, ch_data, req_ready,
        output ch_ready, req_valid, req_time, req_core, req_op, req_addr
    );
endinterface

// File: rtl/trace_char_class.sv
// Combinational ASCII classifier: digit, hex letter, whitespace, newline,
// carriage return, plus the hex nibble value of digits and a-f/A-F.
module trace_char_class
    import trace_pkg::*;
(
    input  logic [7:0] ch,
    output logic       is_dig,
    output logic       is_hex,
    output logic       is_ws,
    output logic       is_nl,
    output logic       is_cr,
    output logic [3:0] nibble
);
    logic is_lc;
    logic is_uc;

    // Classify the character and extract its hex value.
    always_comb begin
        is_dig = (ch >= 8'h30) && (ch <= 8'h39);
        is_lc  = (ch >= 8'h61) && (ch <= 8'h66);
        is_uc  = (ch >= 8'h41) && (ch <= 8'h46);
        is_hex = is_dig || is_lc || is_uc;
        is_ws  = (ch == CH_SP) || (ch == CH_TAB);
        is_nl  = (ch == CH_NL);
        is_cr  = (ch == CH_CR);
        // 'a'/'A' have low nibble 1, so +9 maps them onto 10.
        if (is_dig) begin
            nibble = ch[3:0];
        end else if (is_lc || is_uc) begin
            nibble = ch[3:0] + 4'd9;
        end else begin
            nibble = 4'd0;
        end
    end
endmodule

// File: rtl/trace_line_parser.sv
// Streaming trace-line parser: one ASCII char per cycle in, one decoded
// request per valid "<time> <core> <op> <addr_hex>\n" line out.
// Optional feature: define TRACE_ECHO_EN to add echo_valid/echo_data, a
// registered copy of every accepted character.
module trace_line_parser
    import trace_pkg::*;
#(
    parameter int TIME_W = TRACE_TIME_W,
    parameter int CORE_W = TRACE_CORE_W,
    parameter int ADDR_W = TRACE_ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    trace_line_parser_if.slave bus,
    output logic               err_pulse,
    output logic [31:0]        line_cnt
`ifdef TRACE_ECHO_EN
    ,
    output logic               echo_valid,
    output logic [7:0]         echo_data
`endif
);
    // One accumulator serves every field; it must hold the widest one.
    localparam int ACC_W = (TIME_W > ADDR_W) ? TIME_W : ADDR_W;

    logic is_dig, is_hex, is_ws, is_nl, is_cr;
    logic [3:0] nibble;
    logic xfer;

    state_e            state_q, state_d;
    logic [1:0]        fi_q, fi_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic [CORE_W-1:0] core_q, core_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ch_ready_q, ch_ready_d;
    logic              req_valid_q, req_valid_d;
    logic [TIME_W-1:0] req_time_q, req_time_d;
    logic [CORE_W-1:0] req_core_q, req_core_d;
    op_e               req_op_q, req_op_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              err_q, err_d;
    logic [31:0]       line_cnt_q, line_cnt_d;

    logic [ACC_W-1:0]  acc_dec, acc_hex, acc_step, acc_start;
    logic              op_bad;
    logic              emit;
    logic [ADDR_W-1:0] emit_addr;

    trace_char_class u_class (
        .ch     (bus.ch_data),
        .is_dig (is_dig),
        .is_hex (is_hex),
        .is_ws  (is_ws),
        .is_nl  (is_nl),
        .is_cr  (is_cr),
        .nibble (nibble)
    );

    assign xfer = bus.ch_valid && ch_ready_q;

    // Next accumulator value for the current field and for a fresh field.
    always_comb begin
        acc_dec = acc_q * ACC_W'(10) + ACC_W'(nibble);
        acc_hex = {acc_q[ACC_W-5:0], nibble};
        // The op field saturates at 3 so an oversized value is still caught.
        unique case (fi_q)
            2'd2:    acc_step = (acc_dec > ACC_W'(3)) ? ACC_W'(3) : acc_dec;
            2'd3:    acc_step = acc_hex;
            default: acc_step = acc_dec;
        endcase
        // A field started from GAP with fi_q == 1 is the op field.
        if (fi_q == 2'd1 && nibble > 4'd3) begin
            acc_start = ACC_W'(3);
        end else begin
            acc_start = ACC_W'(nibble);
        end
        op_bad = (fi_q == 2'd2) && (acc_q[1:0] == 2'd3);
    end

    // Line-parsing state machine, field commit and request emission.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d     = state_q;
        fi_d        = fi_q;
        acc_d       = acc_q;
        time_d      = time_q;
        core_d      = core_q;
        op_d        = op_q;
        addr_d      = addr_q;
        req_valid_d = req_valid_q;
        req_time_d  = req_time_q;
        req_core_d  = req_core_q;
        req_op_d    = req_op_q;
        req_addr_d  = req_addr_q;
        err_d       = 1'b0;
        line_cnt_d  = line_cnt_q;
        emit        = 1'b0;
        emit_addr   = addr_q;

        if (xfer && is_nl) begin
            line_cnt_d = line_cnt_q + 32'd1;
        end

        // Carriage returns are accepted but leave the parser untouched.
        if (xfer && !is_cr) begin
            unique case (state_q)
                LINE_START: begin
                    if (is_dig) begin
                        state_d = FIELD;
                        fi_d    = 2'd0;
                        acc_d   = ACC_W'(nibble);
                    end else if (!is_ws && !is_nl) begin
                        err_d   = 1'b1;
                        state_d = DRAIN;
                    end
                end
                FIELD: begin
                    if (is_dig || (is_hex && fi_q == 2'd3)) begin
                        acc_d = acc_step;
                    end else if (is_ws) begin
                        unique case (fi_q)
                            2'd0: time_d = acc_q[TIME_W-1:0];
                            2'd1: core_d = acc_q[CORE_W-1:0];
                            2'd2: op_d   = op_e'(acc_q[1:0]);
                            2'd3: addr_d = acc_q[ADDR_W-1:0];
                        endcase
                        if (op_bad) begin
                            err_d   = 1'b1;
                            state_d = DRAIN;
                        end else begin
                            state_d = GAP;
                        end
                    end else if (is_nl) begin
                        if (fi_q == 2'd3) begin
                            emit      = 1'b1;
                            emit_addr = acc_q[ADDR_W-1:0];
                        end else begin
                            err_d   = 1'b1;
                            state_d = LINE_START;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = DRAIN;
                    end
                end
                GAP: begin
                    if (is_nl) begin
                        if (fi_q == 2'd3) begin
                            emit = 1'b1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = LINE_START;
                        end
                    end else if (is_hex && fi_q != 2'd3 && (is_dig || fi_q == 2'd2)) begin
                        state_d = FIELD;
                        fi_d    = fi_q + 2'd1;
                        acc_d   = acc_start;
                    end else if (!is_ws) begin
                        err_d   = 1'b1;
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (is_nl) begin
                        state_d = LINE_START;
                    end
                end
                default: ;
            endcase
        end

        if (state_q == EMIT && bus.req_ready) begin
            req_valid_d = 1'b0;
            state_d     = LINE_START;
        end

        if (emit) begin
            state_d     = EMIT;
            req_valid_d = 1'b1;
            req_time_d  = time_q;
            req_core_d  = core_q;
            req_op_d    = op_q;
            req_addr_d  = emit_addr;
        end

        // Stall the source for as long as a request is pending.
        ch_ready_d = (state_d != EMIT);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q     <= LINE_START;
            fi_q        <= 2'd0;
            acc_q       <= '0;
            time_q      <= '0;
            core_q      <= '0;
            op_q        <= OP_READ;
            addr_q      <= '0;
            ch_ready_q  <= 1'b0;
            req_valid_q <= 1'b0;
            req_time_q  <= '0;
            req_core_q  <= '0;
            req_op_q    <= OP_READ;
            req_addr_q  <= '0;
            err_q       <= 1'b0;
            line_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            fi_q        <= fi_d;
            acc_q       <= acc_d;
            time_q      <= time_d;
            core_q      <= core_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            ch_ready_q  <= ch_ready_d;
            req_valid_q <= req_valid_d;
            req_time_q  <= req_time_d;
            req_core_q  <= req_core_d;
            req_op_q    <= req_op_d;
            req_addr_q  <= req_addr_d;
            err_q       <= err_d;
            line_cnt_q  <= line_cnt_d;
        end
    end

    assign bus.ch_ready  = ch_ready_q;
    assign bus.req_valid = req_valid_q;
    assign bus.req_time  = req_time_q;
    assign bus.req_core  = req_core_q;
    assign bus.req_op    = req_op_q;
    assign bus.req_addr  = req_addr_q;
    assign err_pulse     = err_q;
    assign line_cnt      = line_cnt_q;

`ifdef TRACE_ECHO_EN
    logic       echo_valid_q;
    logic [7:0] echo_data_q;

    // Registered copy of every accepted character, carriage returns included.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            echo_valid_q <= 1'b0;
            echo_data_q  <= 8'd0;
        end else begin
            echo_valid_q <= xfer;
            echo_data_q  <= bus.ch_data;
        end
    end

    assign echo_valid = echo_valid_q;
    assign echo_data  = echo_data_q;
`endif
endmodule

// File: tb/tb_trace_line_parser.sv
// Self-checking bench for trace_line_parser: a token-level line model feeds a
// request scoreboard, one monitor checks the DUT every cycle, and directed
// tests pin key results with literal values.
module tb_trace_line_parser;
    import trace_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    trace_line_parser_if #(.TIME_W(64), .CORE_W(4), .ADDR_W(34)) bus ();
    logic        err_pulse;
    logic [31:0] line_cnt;
`ifdef TRACE_ECHO_EN
    logic        echo_valid;
    logic [7:0]  echo_data;
`endif

    trace_line_parser #(.TIME_W(64), .CORE_W(4), .ADDR_W(34)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .err_pulse (err_pulse),
        .line_cnt  (line_cnt)
`ifdef TRACE_ECHO_EN
        ,
        .echo_valid(echo_valid),
        .echo_data (echo_data)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    trace_req_t exp_q[$];
    trace_req_t last_req;
    int exp_err = 0;
    int err_seen = 0;
    int exp_lines = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    function automatic int hexval(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        return -1;
    endfunction

    // Token-level model of one line (terminated by newline): kind 0 blank,
    // 1 valid request, 2 malformed.
    function automatic void model_line(input string s, output int kind, output trace_req_t r);
        int ntok = 0;
        bit in_tok = 0;
        bit bad = 0;
        bit letter = 0;
        logic [63:0] dv = 0;
        logic [63:0] hv = 0;
        int opv = 0;
        r = '0;
        for (int i = 0; i < s.len(); i++) begin
            logic [7:0] c;
            int d;
            c = s[i];
            d = hexval(c);
            if (c == 8'h0D) continue;
            if (c == 8'h20 || c == 8'h09 || c == 8'h0A) begin
                if (in_tok) begin
                    in_tok = 0;
                    case (ntok)
                        1: begin if (letter) bad = 1; r.tstamp = dv; end
                        2: begin if (letter) bad = 1; r.core = dv[3:0]; end
                        3: begin if (letter || opv > 2) bad = 1; else r.op = op_e'(opv); end
                        4: r.addr = hv[33:0];
                        default: bad = 1;
                    endcase
                end
                if (c == 8'h0A) break;
            end else if (d < 0) begin
                bad = 1;
            end else begin
                if (!in_tok) begin
                    in_tok = 1; ntok++; dv = 0; hv = 0; opv = 0; letter = 0;
                end
                if (d > 9) letter = 1;
                dv  = dv * 64'd10 + 64'(d);
                hv  = (hv << 4) | 64'(d);
                opv = (opv * 10 + d > 3) ? 3 : opv * 10 + d;
            end
        end
        if (ntok == 0 && !bad) kind = 0;
        else if (bad || ntok != 4) kind = 2;
        else kind = 1;
    endfunction

    task automatic model_apply(input string line);
        int kind;
        trace_req_t r;
        model_line(line, kind, r);
        exp_lines++;
        if (kind == 1) exp_q.push_back(r);
        else if (kind == 2) exp_err++;
    endtask

    // Called at a negedge; returns at the negedge after the transfer.
    task automatic send_char(input logic [7:0] c);
        int waited = 0;
        bus.ch_valid = 1'b1;
        bus.ch_data  = c;
        while (bus.ch_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (bus.ch_ready !== 1'b1) begin
            check("ch_ready_timeout", 64'd0, 64'd1);
            bus.ch_valid = 1'b0;
            return;
        end
        @(negedge clk);
`ifdef TRACE_ECHO_EN
        check("echo_valid", 64'(echo_valid), 64'd1);
        check("echo_data", 64'(echo_data), 64'(c));
`endif
        bus.ch_valid = 1'b0;
    endtask

    task automatic send_raw(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic feed(input string s);
        int start = 0;
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h0A) begin
                model_apply(s.substr(start, i));
                start = i + 1;
            end
        end
        send_raw(s);
    endtask

    task automatic settle(input string tag);
        repeat (4) @(negedge clk);
        #2;
        check({tag, "_pending_reqs"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_err_count"}, 64'(err_seen), 64'(exp_err));
        check({tag, "_line_cnt"}, 64'(line_cnt), 64'(exp_lines));
    endtask

    // Per-cycle monitor: error pulses, pending request fields, stall.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (err_pulse === 1'b1) err_seen++;
                if (bus.req_valid === 1'b1) begin
                    check("ch_ready_low_while_req", 64'(bus.ch_ready), 64'd0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_req", 64'd1, 64'd0);
                    end else begin
                        check("req_time", bus.req_time, exp_q[0].tstamp);
                        check("req_core", 64'(bus.req_core), 64'(exp_q[0].core));
                        check("req_op", 64'(bus.req_op), 64'(exp_q[0].op));
                        check("req_addr", 64'(bus.req_addr), 64'(exp_q[0].addr));
                        if (bus.req_ready === 1'b1) last_req = exp_q.pop_front();
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int l0;
        bus.ch_valid  = 1'b0;
        bus.ch_data   = 8'd0;
        bus.req_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ch_ready", 64'(bus.ch_ready), 64'd0);
        check("rst_req_valid", 64'(bus.req_valid), 64'd0);
        check("rst_err_pulse", 64'(err_pulse), 64'd0);
        check("rst_line_cnt", 64'(line_cnt), 64'd0);
        check("rst_req_time", bus.req_time, 64'd0);
        check("rst_req_addr", 64'(bus.req_addr), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ch_ready_after_rst", 64'(bus.ch_ready), 64'd1);

        // 1: basic read
        feed("10 0 0 1FF\n");
        settle("t1");
        check("t1_time", last_req.tstamp, 64'd10);
        check("t1_core", 64'(last_req.core), 64'd0);
        check("t1_op", 64'(last_req.op), 64'd0);
        check("t1_addr", 64'(last_req.addr), 64'h1FF);
        check("t1_line_cnt", 64'(line_cnt), 64'd1);

        // 2: backpressure for 5 cycles, then next line
        bus.req_ready = 1'b0;
        feed("20 3 1 abc\n");
        for (int i = 0; i < 5; i++) begin
            check("t2_req_valid_held", 64'(bus.req_valid), 64'd1);
            check("t2_ch_ready_low", 64'(bus.ch_ready), 64'd0);
            @(negedge clk);
        end
        bus.req_ready = 1'b1;
        @(negedge clk);
        #2;
        check("t2_time", last_req.tstamp, 64'd20);
        check("t2_core", 64'(last_req.core), 64'd3);
        check("t2_addr", 64'(last_req.addr), 64'hABC);
        feed("21 2 0 5\n");
        settle("t2");
        check("t2b_addr", 64'(last_req.addr), 64'h5);

        // 3: op=3 error line then a valid line
        e0 = err_seen;
        feed("5 1 3 A\n6 1 1 a\n");
        settle("t3");
        check("t3_one_err", 64'(err_seen - e0), 64'd1);
        check("t3_time", last_req.tstamp, 64'd6);
        check("t3_op", 64'(last_req.op), 64'd1);
        check("t3_addr", 64'(last_req.addr), 64'hA);

        // 4: blank lines
        e0 = err_seen;
        l0 = int'(line_cnt);
        feed("\n  \t\n");
        settle("t4");
        check("t4_no_err", 64'(err_seen - e0), 64'd0);
        check("t4_lines", 64'(int'(line_cnt) - l0), 64'd2);

        // 5: carriage return ignored, address truncation
        feed("12 2 2 3FFFFFFFF\015\n");
        settle("t5a");
        check("t5_op", 64'(last_req.op), 64'd2);
        check("t5_addr", 64'(last_req.addr), 64'h3FFFFFFFF);
        feed("1 0 0 FFFFFFFFF\n");
        settle("t5b");
        check("t5_trunc_addr", 64'(last_req.addr), 64'h3FFFFFFFF);

        // Assorted malformed lines, whitespace variants and core wrap
        e0 = err_seen;
        feed("1 2 3 4 5\n1 2\n1 x 0 0\n 9 1 2 G\n3 a 1 1\n  4\t15 2 ff \n9 17 0 0\n");
        settle("tx");
        check("tx_errs", 64'(err_seen - e0), 64'd5);
        check("tx_core_wrap", 64'(last_req.core), 64'd1);

        // 6: reset mid-line
        send_raw("7 0 ");
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_line_cnt", 64'(line_cnt), 64'd0);
        check("t6_rst_ch_ready", 64'(bus.ch_ready), 64'd0);
        rst_n = 1'b1;
        exp_lines = 0;
        feed("8 0 1 10\n");
        settle("t6");
        check("t6_time", last_req.tstamp, 64'd8);
        check("t6_op", 64'(last_req.op), 64'd1);
        check("t6_addr", 64'(last_req.addr), 64'h10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
